// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and UART frame-transmitter handshake bundled for the arbiter.
// master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int FRAME_WD = 8
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*FRAME_WD-1:0] req_data;
  logic [NUM_REQ-1:0]          req_last;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        frame_en;
  logic [FRAME_WD-1:0]         data_frame;
  logic                        tx_done;

  modport master (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, frame_en, data_frame
  );

  modport slave (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, frame_en, data_frame
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked scheduler of NUM_REQ byte streams onto one UART transmitter; req_valid at edge t
// gives frame_en/req_ready at t+1; requesters are held off (no req_ready) while a frame or inter-frame gap is in flight.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int FRAME_WD       = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.master          bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       err_timeout
);
  localparam int IDW     = $clog2(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ARB, WAIT_DONE, GAP} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic                frame_en_q, frame_en_d;
  logic [FRAME_WD-1:0] data_frame_q, data_frame_d;
  logic                busy_q, busy_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic                locked_q, locked_d;
  logic                last_q, last_d;
  logic                err_timeout_q, err_timeout_d;
  logic [IDW-1:0]      ptr_q, ptr_d;

  logic                pick_vld;
  logic [IDW-1:0]      pick_idx;
  logic                wd_expire;
  logic                gap_end;
  logic [FRAME_WD-1:0] req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign req_byte[g] = bus.req_data[g*FRAME_WD +: FRAME_WD];
  end

  // Descending scan so the lowest offset from ptr+1 is the one left standing.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    if (locked_q) begin
      pick_vld = bus.req_valid[grant_id_q];
      pick_idx = grant_id_q;
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (bus.req_valid[IDW'(idx)]) begin
          pick_vld = 1'b1;
          pick_idx = IDW'(idx);
        end
      end
    end
  end

  // tx_done has priority over a watchdog expiry landing on the same edge.
  assign wd_expire = (state_q == WAIT_DONE) && !bus.tx_done &&
                     (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
  assign gap_end   = (cnt_q == CNTW'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB: begin
        cnt_d = '0;
        if (pick_vld) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done || wd_expire) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      GAP: begin
        if (gap_end) begin
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    req_ready_d   = '0;
    frame_en_d    = 1'b0;
    err_timeout_d = 1'b0;
    data_frame_d  = data_frame_q;
    busy_d        = busy_q;
    grant_id_d    = grant_id_q;
    locked_d      = locked_q;
    last_d        = last_q;
    ptr_d         = ptr_q;
    case (state_q)
      ARB: begin
        if (pick_vld) begin
          req_ready_d[pick_idx] = 1'b1;
          frame_en_d            = 1'b1;
          data_frame_d          = req_byte[pick_idx];
          grant_id_d            = pick_idx;
          locked_d              = 1'b1;
          last_d                = bus.req_last[pick_idx];
          busy_d                = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (last_q) begin
            locked_d = 1'b0;
            ptr_d    = grant_id_q;
          end
        end else if (wd_expire) begin
          err_timeout_d = 1'b1;
          locked_d      = 1'b0;
          ptr_d         = grant_id_q;
        end
      end
      GAP: begin
        if (gap_end) busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q   <= '0;
      frame_en_q    <= 1'b0;
      data_frame_q  <= '0;
      busy_q        <= 1'b0;
      grant_id_q    <= '0;
      locked_q      <= 1'b0;
      last_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      ptr_q         <= IDW'(NUM_REQ - 1);
    end else begin
      req_ready_q   <= req_ready_d;
      frame_en_q    <= frame_en_d;
      data_frame_q  <= data_frame_d;
      busy_q        <= busy_d;
      grant_id_q    <= grant_id_d;
      locked_q      <= locked_d;
      last_q        <= last_d;
      err_timeout_q <= err_timeout_d;
      ptr_q         <= ptr_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.frame_en   = frame_en_q;
  assign bus.data_frame = data_frame_q;
  assign busy           = busy_q;
  assign grant_id       = grant_id_q;
  assign locked         = locked_q;
  assign err_timeout    = err_timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round robin, packet lock, owner stall, watchdog, reset.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int FW = 8;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant_id;
  logic       locked;
  logic       err_timeout;

  int n_cmp;
  int n_bad;

  logic [8:0] rq [NR][16];
  int         rq_n [NR];
  int         rq_h [NR];
  logic [NR-1:0] hold;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .FRAME_WD(FW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .FRAME_WD(FW), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .grant_id(grant_id), .locked(locked), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_req();
    for (int i = 0; i < NR; i++) begin
      logic [8:0] e;
      e = (rq_h[i] < rq_n[i]) ? rq[i][rq_h[i]] : 9'd0;
      bus.req_valid[i]       = (rq_h[i] < rq_n[i]) && !hold[i];
      bus.req_data[i*FW +: FW] = e[7:0];
      bus.req_last[i]        = e[8];
    end
  endtask

  task automatic push(input int i, input logic last, input logic [7:0] d);
    rq[i][rq_n[i]] = {last, d};
    rq_n[i]++;
  endtask

  task automatic pop_ready();
    for (int i = 0; i < NR; i++)
      if (bus.req_ready[i] === 1'b1) rq_h[i]++;
    apply_req();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 0);
    chk({tag, "_fe"}, 32'(bus.frame_en), 0);
    chk({tag, "_dat"}, 32'(bus.data_frame), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_gid"}, 32'(grant_id), 0);
    chk({tag, "_lock"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err_timeout), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.tx_done = 1'b0;
    hold = '0;
    for (int i = 0; i < NR; i++) begin
      rq_n[i] = 0;
      rq_h[i] = 0;
    end
    apply_req();
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
  endtask

  // Polls (bounded) for the next frame_en and checks who got it.
  task automatic expect_frame(input string tag, input int exp_id, input logic [7:0] exp_dat);
    int n;
    n = 0;
    while (bus.frame_en !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_fe"}, 32'(bus.frame_en), 1);
    chk({tag, "_gid"}, 32'(grant_id), 32'(exp_id));
    chk({tag, "_dat"}, 32'(bus.data_frame), 32'(exp_dat));
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(1) << exp_id);
    pop_ready();
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] exp_dat, input logic exp_lock);
    repeat (3) tick();
    chk({tag, "_hold"}, 32'(bus.data_frame), 32'(exp_dat));
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk({tag, "_lock"}, 32'(locked), 32'(exp_lock));
    chk({tag, "_err"}, 32'(err_timeout), 0);
  endtask

  initial begin
    int fe_cnt;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    do_reset();

    // Round robin from reset pointer: 0,1,2,3 then 0 on refill.
    push(0, 1'b1, 8'h10); push(1, 1'b1, 8'h21);
    push(2, 1'b1, 8'h32); push(3, 1'b1, 8'h43);
    push(0, 1'b1, 8'h54);
    apply_req();
    expect_frame("rr0", 0, 8'h10); finish_frame("rr0", 8'h10, 1'b0);
    expect_frame("rr1", 1, 8'h21); finish_frame("rr1", 8'h21, 1'b0);
    expect_frame("rr2", 2, 8'h32); finish_frame("rr2", 8'h32, 1'b0);
    expect_frame("rr3", 3, 8'h43); finish_frame("rr3", 8'h43, 1'b0);
    expect_frame("rr4", 0, 8'h54); finish_frame("rr4", 8'h54, 1'b0);

    // Single byte: exact one-edge latency and gap timing.
    repeat (5) tick();
    push(0, 1'b1, 8'h55);
    apply_req();
    tick();
    chk("sb_fe", 32'(bus.frame_en), 1);
    chk("sb_rdy", 32'(bus.req_ready), 1);
    chk("sb_dat", 32'(bus.data_frame), 32'h55);
    chk("sb_lock", 32'(locked), 1);
    chk("sb_busy", 32'(busy), 1);
    pop_ready();
    tick();
    chk("sb_fe_off", 32'(bus.frame_en), 0);
    chk("sb_rdy_off", 32'(bus.req_ready), 0);
    repeat (3) tick();
    chk("sb_hold", 32'(bus.data_frame), 32'h55);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("sb_unlock", 32'(locked), 0);
    chk("sb_busy_g0", 32'(busy), 1);
    tick();
    chk("sb_busy_g1", 32'(busy), 1);
    tick();
    chk("sb_busy_end", 32'(busy), 0);

    // Packet lock: req0 3-byte packet holds off req1.
    do_reset();
    push(0, 1'b0, 8'hA0); push(0, 1'b0, 8'hA1); push(0, 1'b1, 8'hA2);
    push(1, 1'b1, 8'hB0);
    apply_req();
    expect_frame("pk0", 0, 8'hA0); finish_frame("pk0", 8'hA0, 1'b1);
    expect_frame("pk1", 0, 8'hA1); finish_frame("pk1", 8'hA1, 1'b1);
    expect_frame("pk2", 0, 8'hA2); finish_frame("pk2", 8'hA2, 1'b0);
    expect_frame("pk3", 1, 8'hB0); finish_frame("pk3", 8'hB0, 1'b0);

    // Owner stall: req0 drops valid mid-packet, req2 must wait.
    do_reset();
    push(0, 1'b0, 8'hC0); push(0, 1'b0, 8'hC1); push(0, 1'b1, 8'hC2);
    push(2, 1'b1, 8'hD0);
    apply_req();
    expect_frame("st0", 0, 8'hC0);
    hold[0] = 1'b1;
    apply_req();
    finish_frame("st0", 8'hC0, 1'b1);
    fe_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.frame_en === 1'b1) fe_cnt++;
    end
    chk("st_nofe", 32'(fe_cnt), 0);
    chk("st_lock", 32'(locked), 1);
    hold[0] = 1'b0;
    apply_req();
    expect_frame("st1", 0, 8'hC1); finish_frame("st1", 8'hC1, 1'b1);
    expect_frame("st2", 0, 8'hC2); finish_frame("st2", 8'hC2, 1'b0);
    expect_frame("st3", 2, 8'hD0); finish_frame("st3", 8'hD0, 1'b0);

    // Watchdog: no tx_done, abort at cycle 50, next frame to req1.
    do_reset();
    push(0, 1'b0, 8'hE0); push(0, 1'b1, 8'hE1);
    push(1, 1'b1, 8'hF0);
    apply_req();
    expect_frame("to0", 0, 8'hE0);
    repeat (49) tick();
    chk("to_err49", 32'(err_timeout), 0);
    chk("to_lock49", 32'(locked), 1);
    tick();
    chk("to_err50", 32'(err_timeout), 1);
    chk("to_unlock", 32'(locked), 0);
    tick();
    chk("to_err_pulse", 32'(err_timeout), 0);
    expect_frame("to1", 1, 8'hF0); finish_frame("to1", 8'hF0, 1'b0);
    expect_frame("to2", 0, 8'hE1); finish_frame("to2", 8'hE1, 1'b0);

    // tx_done on the watchdog's limit edge wins.
    do_reset();
    push(0, 1'b1, 8'h77);
    apply_req();
    expect_frame("sim", 0, 8'h77);
    repeat (49) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("sim_err", 32'(err_timeout), 0);
    chk("sim_lock", 32'(locked), 0);
    chk("sim_busy", 32'(busy), 1);
    tick();
    chk("sim_err2", 32'(err_timeout), 0);

    // Async reset in WAIT_DONE clears outputs before any clock edge.
    do_reset();
    push(2, 1'b1, 8'h99);
    apply_req();
    expect_frame("ar", 2, 8'h99);
    repeat (2) tick();
    chk("ar_lock_pre", 32'(locked), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("ar");
    tick();
    tick();
    chk("ar_no_reissue", 32'(bus.frame_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
